// File: rtl/timer_run_ctrl.sv
// timer_run_ctrl: run controller for the seven-segment TIMER datapath.
// Debounces the run/pause and clear buttons, runs the IDLE/RUN/PAUSE/DONE
// state machine, issues the count tick and counter-clear pulse, and
// free-runs the digit-scan index.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   btn_run_i    raw run/pause button (asynchronous, active-high)
//   btn_clr_i    raw clear button (asynchronous, active-high)
//   time_zero_i  datapath count has reached its terminal value
//   tick_o       one-cycle count-enable pulse
//   cnt_clr_o    one-cycle counter-clear pulse
//   running_o    high in RUN
//   done_o       high in DONE
//   scan_idx_o   current digit select (0..DIGITS-1)
module timer_run_ctrl #(
   parameter int unsigned TICK_DIV   = 100000000,
   parameter int unsigned DEB_CYCLES = 1000000,
   parameter int unsigned SCAN_DIV   = 100000,
   parameter int unsigned DIGITS     = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       btn_run_i,
   input  logic       btn_clr_i,
   input  logic       time_zero_i,
   output logic       tick_o,
   output logic       cnt_clr_o,
   output logic       running_o,
   output logic       done_o,
   output logic [2:0] scan_idx_o
);

   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DebW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [TickW-1:0] TickMax  = TickW'(TICK_DIV - 1);
   localparam logic [DebW-1:0]  DebMax   = DebW'(DEB_CYCLES - 1);
   localparam logic [ScanW-1:0] ScanMax  = ScanW'(SCAN_DIV - 1);
   localparam logic [2:0]       ScanLast = 3'(DIGITS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

   // Button lanes: bit 0 = run, bit 1 = clear.
   logic [1:0]      meta_q;
   logic [1:0]      sync_q;
   logic [1:0]      level_q;
   logic [1:0]      level_d;
   logic [1:0]      level_prev_q;
   logic [1:0]      press_q;
   logic [DebW-1:0] deb_cnt_q [2];
   logic [DebW-1:0] deb_cnt_d [2];

   logic run_press;
   logic clr_press;

   state_e           state_q;
   logic [TickW-1:0] pres_q;
   logic             tick_q;
   logic             cnt_clr_q;
   logic             running_q;
   logic             done_q;

   logic [ScanW-1:0] scan_cnt_q;
   logic [ScanW-1:0] scan_cnt_d;
   logic [2:0]       scan_idx_q;
   logic [2:0]       scan_idx_d;

   // Debounce: the accepted level only follows the synchronized input after it
   // has disagreed for DEB_CYCLES consecutive cycles.
   always_comb begin
      level_d   = level_q;
      deb_cnt_d = deb_cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync_q[i] == level_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (deb_cnt_q[i] == DebMax) begin
            level_d[i]   = sync_q[i];
            deb_cnt_d[i] = '0;
         end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q       <= '0;
         sync_q       <= '0;
         level_q      <= '0;
         level_prev_q <= '0;
         press_q      <= '0;
         deb_cnt_q    <= '{default: '0};
      end else begin
         meta_q       <= {btn_clr_i, btn_run_i};
         sync_q       <= meta_q;
         level_q      <= level_d;
         level_prev_q <= level_q;
         // Rising edge of the accepted level only; release is ignored.
         press_q      <= level_q & ~level_prev_q;
         deb_cnt_q    <= deb_cnt_d;
      end
   end

   assign run_press = press_q[0];
   assign clr_press = press_q[1];

   // Run FSM. Branch order encodes priority: clear > time_zero > run > tick.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         pres_q    <= '0;
         tick_q    <= 1'b0;
         cnt_clr_q <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         tick_q    <= 1'b0;
         cnt_clr_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (clr_press) begin
                  cnt_clr_q <= 1'b1;
               end else if (run_press) begin
                  state_q   <= StRun;
                  pres_q    <= '0;
                  running_q <= 1'b1;
               end
            end
            StRun: begin
               if (clr_press) begin
                  state_q   <= StIdle;
                  cnt_clr_q <= 1'b1;
                  pres_q    <= '0;
                  running_q <= 1'b0;
               end else if (time_zero_i) begin
                  state_q   <= StDone;
                  pres_q    <= '0;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
               end else if (run_press) begin
                  // Prescaler keeps its phase so a resume finishes the interrupted second.
                  state_q   <= StPause;
                  running_q <= 1'b0;
               end else if (pres_q == TickMax) begin
                  tick_q <= 1'b1;
                  pres_q <= '0;
               end else begin
                  pres_q <= pres_q + TickW'(1);
               end
            end
            StPause: begin
               if (clr_press) begin
                  state_q   <= StIdle;
                  cnt_clr_q <= 1'b1;
                  pres_q    <= '0;
               end else if (run_press) begin
                  state_q   <= StRun;
                  running_q <= 1'b1;
               end
            end
            StDone: begin
               if (clr_press) begin
                  state_q   <= StIdle;
                  cnt_clr_q <= 1'b1;
                  done_q    <= 1'b0;
               end
            end
            default: begin
               state_q   <= StIdle;
               pres_q    <= '0;
               running_q <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

   // Digit scan, free-running regardless of FSM state.
   always_comb begin
      scan_cnt_d = scan_cnt_q + ScanW'(1);
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == ScanMax) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == ScanLast) ? 3'd0 : scan_idx_q + 3'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
      end
   end

   assign tick_o     = tick_q;
   assign cnt_clr_o  = cnt_clr_q;
   assign running_o  = running_q;
   assign done_o     = done_q;
   assign scan_idx_o = scan_idx_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Bench for timer_run_ctrl: directed scenarios plus randomized button and
// time_zero activity, all compared every cycle against a behavioural model.
module tb_timer_run_ctrl;

   localparam int TD = 10;
   localparam int DB = 4;
   localparam int SD = 3;
   localparam int DG = 8;

   localparam int MIdle  = 0;
   localparam int MRun   = 1;
   localparam int MPause = 2;
   localparam int MDone  = 3;

   logic       clk;
   logic       rst_n;
   logic       btn_run;
   logic       btn_clr;
   logic       time_zero;
   logic       tick;
   logic       cnt_clr;
   logic       running;
   logic       done;
   logic [2:0] scan_idx;

   int compared;
   int mismatched;

   timer_run_ctrl #(
      .TICK_DIV  (TD),
      .DEB_CYCLES(DB),
      .SCAN_DIV  (SD),
      .DIGITS    (DG)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .btn_run_i  (btn_run),
      .btn_clr_i  (btn_clr),
      .time_zero_i(time_zero),
      .tick_o     (tick),
      .cnt_clr_o  (cnt_clr),
      .running_o  (running),
      .done_o     (done),
      .scan_idx_o (scan_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Buttons: raw -> two-edge delay -> accepted level flips once the last DB
   // samples all disagree with it -> press = level rose on the previous edge.
   // Run logic: prescaler phase counts RUN cycles modulo TD.
   // Scan index: (edges since reset / SD) mod DG.
   logic [1:0]    m_r1;
   logic [1:0]    m_s;
   logic [1:0]    m_l;
   logic [1:0]    m_lp;
   logic [1:0]    m_p;
   logic [DB-1:0] m_hist [2];
   int            m_state;
   int            m_pres;
   int            m_edges;
   logic          m_tick;
   logic          m_clr;

   task automatic model_step();
      logic [1:0] raw;
      logic       run_p;
      logic       clr_p;
      logic       new_l;
      raw   = {btn_clr, btn_run};
      run_p = m_p[0];
      clr_p = m_p[1];
      for (int b = 0; b < 2; b++) begin
         m_hist[b] = {m_hist[b][DB-2:0], m_s[b]};
         new_l     = (m_hist[b] == {DB{~m_l[b]}}) ? ~m_l[b] : m_l[b];
         m_p[b]    = m_l[b] & ~m_lp[b];
         m_lp[b]   = m_l[b];
         m_l[b]    = new_l;
         m_s[b]    = m_r1[b];
         m_r1[b]   = raw[b];
      end
      m_tick = 1'b0;
      m_clr  = 1'b0;
      case (m_state)
         MIdle: begin
            if (clr_p) m_clr = 1'b1;
            else if (run_p) begin m_state = MRun; m_pres = 0; end
         end
         MRun: begin
            if (clr_p) begin m_state = MIdle; m_clr = 1'b1; m_pres = 0; end
            else if (time_zero) begin m_state = MDone; m_pres = 0; end
            else if (run_p) m_state = MPause;
            else begin
               m_pres++;
               if (m_pres == TD) begin m_pres = 0; m_tick = 1'b1; end
            end
         end
         MPause: begin
            if (clr_p) begin m_state = MIdle; m_clr = 1'b1; m_pres = 0; end
            else if (run_p) m_state = MRun;
         end
         default: begin
            if (clr_p) begin m_state = MIdle; m_clr = 1'b1; end
         end
      endcase
      m_edges++;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_r1 = '0; m_s = '0; m_l = '0; m_lp = '0; m_p = '0;
         m_hist[0] = '0; m_hist[1] = '0;
         m_state = MIdle; m_pres = 0; m_edges = 0;
         m_tick = 1'b0; m_clr = 1'b0;
      end else begin
         model_step();
      end
   end

   function automatic logic [6:0] exp_vec();
      return {m_tick, m_clr, (m_state == MRun), (m_state == MDone), 3'((m_edges / SD) % DG)};
   endfunction

   function automatic logic [6:0] dut_vec();
      return {tick, cnt_clr, running, done, scan_idx};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      compared++;
      if (dut_vec() !== 7'd0) begin
         mismatched++;
         $display("FAIL reset_outputs: got %b want %b", dut_vec(), 7'd0);
      end
      @(negedge clk);
      compared++;
      if (dut_vec() !== 7'd0) begin
         mismatched++;
         $display("FAIL reset_held: got %b want %b", dut_vec(), 7'd0);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_start_tick();
      int rise;
      int last_t;
      int nt;
      rise = -1;
      btn_run = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL start_cycle %0d: got %b want %b", k, dut_vec(), exp_vec());
         end
         if (running === 1'b1 && rise < 0) rise = k;
      end
      btn_run = 1'b0;
      compared++;
      if (!(rise > 0 && rise <= 8)) begin
         mismatched++;
         $display("FAIL start_latency: got %0d cycles want 1..8", rise);
      end
      last_t = -1;
      nt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL tick_cycle %0d: got %b want %b", k, dut_vec(), exp_vec());
         end
         if (tick === 1'b1) begin
            if (last_t >= 0) begin
               compared++;
               if (k - last_t != TD) begin
                  mismatched++;
                  $display("FAIL tick_period: got %0d want %0d", k - last_t, TD);
               end
            end
            last_t = k;
            nt++;
         end
      end
      compared++;
      if (nt != 4) begin
         mismatched++;
         $display("FAIL tick_count: got %0d want 4", nt);
      end
      // Short glitch must not be accepted.
      btn_run = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL glitch_cycle %0d: got %b want %b", k, dut_vec(), exp_vec());
         end
         if (k == 3) btn_run = 1'b0;
      end
      compared++;
      if (running !== 1'b1) begin
         mismatched++;
         $display("FAIL glitch_running: got %b want 1", running);
      end
   endtask

   task automatic test_pause_resume();
      bit found;
      int nt;
      int rise;
      int tk;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL pause_wait: got %b want %b", dut_vec(), exp_vec());
         end
         if (m_state == MRun && m_pres == 7) found = 1'b1;
      end
      compared++;
      if (!found) begin
         mismatched++;
         $display("FAIL pause_align: got no phase 7 want phase 7 within 20 cycles");
      end
      // Pulse lands 7 edges later, at prescaler phase 4.
      btn_run = 1'b1;
      nt = 0;
      for (int k = 1; k <= 58; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL pause_cycle %0d: got %b want %b", k, dut_vec(), exp_vec());
         end
         if (k == 8) btn_run = 1'b0;
         if (k > 8 && tick === 1'b1) nt++;
      end
      compared++;
      if (nt != 0 || running !== 1'b0) begin
         mismatched++;
         $display("FAIL pause_hold: got ticks=%0d running=%b want ticks=0 running=0", nt, running);
      end
      btn_run = 1'b1;
      rise = -1;
      tk = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL resume_cycle %0d: got %b want %b", k, dut_vec(), exp_vec());
         end
         if (k == 8) btn_run = 1'b0;
         if (running === 1'b1 && rise < 0) rise = k;
         if (tick === 1'b1 && rise > 0 && tk < 0) tk = k;
      end
      compared++;
      if (rise < 0 || tk < 0 || tk - rise != 6) begin
         mismatched++;
         $display("FAIL resume_first_tick: got rise=%0d tick=%0d want gap 6", rise, tk);
      end
   endtask

   task automatic test_done();
      bit found;
      int bad;
      int nc;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL done_wait: got %b want %b", dut_vec(), exp_vec());
         end
         if (m_state == MRun && m_pres == TD - 1) found = 1'b1;
      end
      compared++;
      if (!found) begin
         mismatched++;
         $display("FAIL done_align: got no phase 9 want phase 9 within 20 cycles");
      end
      time_zero = 1'b1;
      @(negedge clk);
      time_zero = 1'b0;
      compared++;
      if (tick !== 1'b0 || done !== 1'b1) begin
         mismatched++;
         $display("FAIL done_entry: got tick=%b done=%b want tick=0 done=1", tick, done);
      end
      btn_run = 1'b1;
      bad = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL done_cycle %0d: got %b want %b", k, dut_vec(), exp_vec());
         end
         if (k == 8) btn_run = 1'b0;
         if (done !== 1'b1 || tick !== 1'b0) bad++;
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("FAIL done_ignores_run: got %0d bad cycles want 0", bad);
      end
      btn_clr = 1'b1;
      nc = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL done_clr_cycle %0d: got %b want %b", k, dut_vec(), exp_vec());
         end
         if (k == 8) btn_clr = 1'b0;
         if (cnt_clr === 1'b1) nc++;
      end
      compared++;
      if (nc != 1 || done !== 1'b0 || running !== 1'b0) begin
         mismatched++;
         $display("FAIL done_clear: got clr=%0d done=%b run=%b want 1/0/0", nc, done, running);
      end
   endtask

   task automatic test_coincident();
      int nc;
      int bad;
      btn_run = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL coin_start %0d: got %b want %b", k, dut_vec(), exp_vec());
         end
         if (k == 8) btn_run = 1'b0;
      end
      compared++;
      if (running !== 1'b1) begin
         mismatched++;
         $display("FAIL coin_running: got %b want 1", running);
      end
      btn_run = 1'b1;
      btn_clr = 1'b1;
      nc = 0;
      bad = 0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL coin_cycle %0d: got %b want %b", k, dut_vec(), exp_vec());
         end
         if (k == 8) begin btn_run = 1'b0; btn_clr = 1'b0; end
         if (cnt_clr === 1'b1) nc++;
         if (nc > 0 && (tick !== 1'b0 || running !== 1'b0)) bad++;
      end
      compared++;
      if (nc != 1 || bad != 0) begin
         mismatched++;
         $display("FAIL coin_clear: got clr=%0d bad=%0d want clr=1 bad=0", nc, bad);
      end
   endtask

   task automatic test_scan();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         compared++;
         if (scan_idx !== 3'((n / SD) % DG)) begin
            mismatched++;
            $display("FAIL scan_idx n=%0d: got %0d want %0d", n, scan_idx, (n / SD) % DG);
         end
         if (n == 30) btn_run = 1'b1;
         if (n == 38) btn_run = 1'b0;
      end
      compared++;
      if (running !== 1'b1) begin
         mismatched++;
         $display("FAIL scan_in_run: got running=%b want 1", running);
      end
   endtask

   task automatic test_async_reset();
      int nc;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if (dut_vec() !== 7'd0) begin
         mismatched++;
         $display("FAIL async_reset: got %b want %b", dut_vec(), 7'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      nc = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL post_reset %0d: got %b want %b", k, dut_vec(), exp_vec());
         end
         if (cnt_clr === 1'b1) nc++;
      end
      compared++;
      if (nc != 0 || running !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("FAIL post_reset_idle: got clr=%0d run=%b done=%b want 0/0/0", nc, running, done);
      end
   endtask

   task automatic test_random();
      int hold_r;
      int hold_c;
      hold_r = 0;
      hold_c = 0;
      for (int k = 1; k <= 1500; k++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL random_cycle %0d: got %b want %b", k, dut_vec(), exp_vec());
         end
         if (hold_r == 0) begin
            btn_run = 1'($urandom_range(0, 1));
            hold_r  = $urandom_range(1, 12);
         end
         if (hold_c == 0) begin
            btn_clr = ($urandom_range(0, 3) == 0);
            hold_c  = $urandom_range(1, 14);
         end
         hold_r--;
         hold_c--;
         time_zero = ($urandom_range(0, 23) == 0);
      end
      btn_run = 1'b0;
      btn_clr = 1'b0;
      time_zero = 1'b0;
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      btn_run = 1'b0;
      btn_clr = 1'b0;
      time_zero = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      test_reset();
      test_start_tick();
      test_pause_resume();
      test_done();
      test_coincident();
      test_scan();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/timer_run_ctrl.md
Name: timer_run_ctrl

Overview:
Run controller for the seven-segment TIMER datapath. It debounces the run/pause and clear buttons and runs a start/pause/done state machine. It issues the 1 s count tick and the counter-clear pulse to the datapath, and free-runs the digit-scan index that drives seg_an. It sits between the board buttons and TIMER inside Top.

Parameters:
TICK_DIV, 100000000, clk cycles per count tick (1 s at 100 MHz)
DEB_CYCLES, 1000000, cycles a synchronized button level must be stable to be accepted (10 ms)
SCAN_DIV, 100000, clk cycles per digit-scan step
DIGITS, 8, number of scanned digits; scan_idx wraps at DIGITS-1 (2..8)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
btn_run  input  1  raw run/pause button, asynchronous, active-high
btn_clr  input  1  raw clear button, asynchronous, active-high
time_zero  input  1  from datapath: count value has reached its terminal value
tick  output  1  one-cycle count-enable pulse to datapath
cnt_clr  output  1  one-cycle clear pulse to datapath
running  output  1  high in RUN state
done  output  1  high in DONE state
scan_idx  output  3  current digit select, feeds seg_an

Behaviour:
- Reset (rst=0, async): state=IDLE; tick, cnt_clr, running, done, scan_idx = 0; prescaler, scan counter and debounce counters = 0; debounced levels = 0; sync flops = 0.
- Input sync: each button passes through a 2-FF synchronizer; output s.
- Debounce, per button:
  - Holds stable level L and counter c.
  - If s==L: c<=0.
  - Else if c==DEB_CYCLES-1: L<=s, c<=0.
  - Else c<=c+1.
  - A glitch shorter than DEB_CYCLES cycles never changes L.
- Press detection: press pulse = L & ~L_prev, registered. It is high one cycle, one cycle after L rises. Release generates nothing.
- Press latency: a clean raw edge is at least 2 (sync) + DEB_CYCLES + 1 cycles before its press pulse.
- FSM (registered; a press acts in the cycle its pulse is high, and the new state is visible next cycle):
  - IDLE: run_press -> RUN, prescaler<=0. clr_press -> cnt_clr=1, stay in IDLE.
  - RUN:
    - Prescaler counts 0..TICK_DIV-1. At TICK_DIV-1, tick=1 for one cycle and the prescaler wraps to 0.
    - time_zero=1 -> DONE, no tick that cycle, prescaler<=0.
    - run_press -> PAUSE, prescaler holds its value.
    - clr_press -> IDLE, cnt_clr=1, prescaler<=0.
  - PAUSE: prescaler frozen, no ticks. run_press -> RUN, prescaler resumes from the held value. clr_press -> IDLE, cnt_clr=1, prescaler<=0.
  - DONE: done=1, no ticks, run_press ignored. clr_press -> IDLE, cnt_clr=1.
- Priority within one cycle: clr_press > time_zero > run_press > prescaler tick.
- cnt_clr and tick are registered, asserted for exactly one cycle, and never high in the same cycle.
- running=1 iff state==RUN; done=1 iff state==DONE. Both are registered from the state.
- Scan:
  - The scan counter is free-running in all states.
  - scan_idx increments when the scan counter hits SCAN_DIV-1; the counter then returns to 0.
  - scan_idx wraps from DIGITS-1 to 0 and never takes values >= DIGITS.
- Reset mid-operation: all state is cleared immediately, with no cnt_clr pulse. After rst returns high, the block behaves exactly as at power-up.
- Counter widths: use clog2 of each divisor; no overflow is permitted at the default values.

Test Plan:
(All scenarios use TICK_DIV=10, DEB_CYCLES=4, SCAN_DIV=3, DIGITS=8.)
1. Release rst, hold btn_run high for 20 cycles -> one run_press. running rises at most 8 cycles after the raw edge, then tick pulses every 10 cycles. Hold btn_run for 3 cycles -> no state change.
2. In RUN, 4 cycles after a tick, press run -> PAUSE, no ticks for 50 cycles. Press run again -> first tick arrives 6 cycles after RUN resumes.
3. In RUN, drive time_zero=1 on the cycle the prescaler reaches 9 -> no tick, done=1 next cycle. A following run_press leaves the state in DONE; clr_press gives one cnt_clr cycle and returns to IDLE.
4. Make run_press and clr_press coincide while in RUN -> cnt_clr=1 for one cycle, state IDLE, tick stays 0.
5. Run free for 30 cycles -> scan_idx steps 0,1,...,7,0,1 every 3 cycles; 8 steps span 24 cycles. Behaviour is identical in IDLE and RUN.
6. Assert rst=0 asynchronously mid-RUN, between clock edges -> running, tick and scan_idx go to 0 before the next edge, and no cnt_clr is generated. After release, the block is in IDLE.
